// File: rtl/visited_arbiter.sv
// ---------------------------------------------------------------------------
// visited_arbiter
//
// Shares one single-port, 1-bit visited-bitmap BRAM among NUM_REQ BFS
// processing elements. Each accepted request performs an atomic
// test-and-set on one vertex bit: the bit is read, set if it was clear,
// and the requester is told whether the vertex had already been visited.
// Requesters are served round-robin. Between traversals the block sweeps
// the whole bitmap back to zero on request.
//
// Ports
//   clk_in            system clock, rising edge
//   rst_in            asynchronous active-high reset
//   clear_in          one-cycle pulse requesting a full bitmap clear
//   req_valid_in      per-requester request valid, held until accepted
//   req_addr_in       packed vertex addresses, requester i at [i*ADDR_W +: ADDR_W]
//   req_ready_out     one-hot accept (only in IDLE)
//   resp_valid_out    one-hot, one-cycle response pulse to the granted requester
//   resp_visited_out  1 = vertex was already visited, 0 = newly visited
//   busy_out          high whenever the block is not idle
//   ram_addr_out      BRAM address
//   ram_we_out        BRAM write enable
//   ram_din_out       BRAM write data
//   ram_dout_in       BRAM read data (RD_LAT cycles after the address)
// ---------------------------------------------------------------------------
module visited_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ADDR_W  = 10,
    parameter int RD_LAT  = 2
) (
    input  logic                      clk_in,
    input  logic                      rst_in,
    input  logic                      clear_in,
    input  logic [NUM_REQ-1:0]        req_valid_in,
    input  logic [NUM_REQ*ADDR_W-1:0] req_addr_in,
    output logic [NUM_REQ-1:0]        req_ready_out,
    output logic [NUM_REQ-1:0]        resp_valid_out,
    output logic                      resp_visited_out,
    output logic                      busy_out,
    output logic [ADDR_W-1:0]         ram_addr_out,
    output logic                      ram_we_out,
    output logic                      ram_din_out,
    input  logic                      ram_dout_in
);

    localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int CNT_W = $clog2(RD_LAT + 2);

    // Last READ cycle is the one where the BRAM output reflects our address.
    localparam logic [CNT_W-1:0]  RD_LAST  = CNT_W'(RD_LAT);
    localparam logic [ADDR_W:0]   CLR_LAST = {1'b0, {ADDR_W{1'b1}}};
    localparam logic [PTR_W-1:0]  PTR_MAX  = PTR_W'(NUM_REQ - 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        SET,
        CLEAR
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   rr_ptr_q, rr_ptr_d;
    logic [PTR_W-1:0]   gnt_q, gnt_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [CNT_W-1:0]   rd_cnt_q, rd_cnt_d;
    logic [ADDR_W:0]    clr_cnt_q, clr_cnt_d;
    logic               hit_q, hit_d;
    logic               clr_pend_q, clr_pend_d;

    logic               gnt_found;
    logic [PTR_W-1:0]   gnt_idx;
    logic [PTR_W-1:0]   cand_idx;
    int                 cand;

    // Circular search for the first valid requester at or after rr_ptr.
    always_comb begin
        gnt_found = 1'b0;
        gnt_idx   = '0;
        cand      = 0;
        cand_idx  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand     = (int'(rr_ptr_q) + i) % NUM_REQ;
            cand_idx = PTR_W'(cand);
            if (!gnt_found && req_valid_in[cand_idx]) begin
                gnt_found = 1'b1;
                gnt_idx   = cand_idx;
            end
        end
    end

    // State register and datapath registers.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_q    <= IDLE;
            rr_ptr_q   <= '0;
            gnt_q      <= '0;
            addr_q     <= '0;
            rd_cnt_q   <= '0;
            clr_cnt_q  <= '0;
            hit_q      <= 1'b0;
            clr_pend_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            gnt_q      <= gnt_d;
            addr_q     <= addr_d;
            rd_cnt_q   <= rd_cnt_d;
            clr_cnt_q  <= clr_cnt_d;
            hit_q      <= hit_d;
            clr_pend_q <= clr_pend_d;
        end
    end

    // Next-state and output decode.
    always_comb begin
        state_d        = state_q;
        rr_ptr_d       = rr_ptr_q;
        gnt_d          = gnt_q;
        addr_d         = addr_q;
        rd_cnt_d       = rd_cnt_q;
        clr_cnt_d      = clr_cnt_q;
        hit_d          = hit_q;
        clr_pend_d     = clr_pend_q;
        req_ready_out  = '0;
        resp_valid_out = '0;
        ram_addr_out   = '0;
        ram_we_out     = 1'b0;
        ram_din_out    = 1'b0;

        case (state_q)
            IDLE: begin
                // A clear always wins over waiting requests.
                if (clear_in || clr_pend_q) begin
                    clr_pend_d = 1'b0;
                    clr_cnt_d  = '0;
                    state_d    = CLEAR;
                end else if (gnt_found) begin
                    // Ready is combinational from valid, so it is masked
                    // while reset is asserted to keep all outputs at zero.
                    req_ready_out[gnt_idx] = ~rst_in;
                    gnt_d    = gnt_idx;
                    addr_d   = req_addr_in[gnt_idx*ADDR_W +: ADDR_W];
                    rr_ptr_d = (gnt_idx == PTR_MAX) ? '0 : gnt_idx + PTR_W'(1);
                    rd_cnt_d = '0;
                    state_d  = READ;
                end
            end

            READ: begin
                ram_addr_out = addr_q;
                if (rd_cnt_q == RD_LAST) begin
                    hit_d   = ram_dout_in;
                    state_d = SET;
                end else begin
                    rd_cnt_d = rd_cnt_q + CNT_W'(1);
                end
            end

            SET: begin
                // BRAM is read-first, so the write here cannot disturb
                // the value already sampled into hit.
                ram_addr_out          = addr_q;
                resp_valid_out[gnt_q] = 1'b1;
                if (!hit_q) begin
                    ram_we_out  = 1'b1;
                    ram_din_out = 1'b1;
                end
                state_d = IDLE;
            end

            CLEAR: begin
                ram_addr_out = clr_cnt_q[ADDR_W-1:0];
                ram_we_out   = 1'b1;
                if (clr_cnt_q == CLR_LAST) begin
                    state_d = IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase

        // A clear seen while busy is remembered and serviced from IDLE.
        if (state_q != IDLE && clear_in) begin
            clr_pend_d = 1'b1;
        end
    end

    // hit only changes on the last READ cycle, so it already holds the
    // previous response outside SET.
    assign resp_visited_out = hit_q;
    assign busy_out         = (state_q != IDLE);

endmodule

// File: tb/tb_visited_arbiter.sv
// ---------------------------------------------------------------------------
// tb_visited_arbiter
//
// Self-checking bench for visited_arbiter. A read-first BRAM model with
// RD_LAT pipeline stages sits on the RAM port. A reference model tracks the
// visited set, the round-robin pointer and the busy intervals in plain
// cycle arithmetic; every accept pushes the expected response into a queue
// that the response monitor drains.
// ---------------------------------------------------------------------------
module tb_visited_arbiter;

    localparam int NUM_REQ = 4;
    localparam int ADDR_W  = 10;
    localparam int RD_LAT  = 2;
    localparam int DEPTH   = 1 << ADDR_W;
    localparam int NO_CLR  = -100000;

    logic                      clk_in = 1'b0;
    logic                      rst_in;
    logic                      clear_in;
    logic [NUM_REQ-1:0]        req_valid_in;
    logic [NUM_REQ*ADDR_W-1:0] req_addr_in;
    logic [NUM_REQ-1:0]        req_ready_out;
    logic [NUM_REQ-1:0]        resp_valid_out;
    logic                      resp_visited_out;
    logic                      busy_out;
    logic [ADDR_W-1:0]         ram_addr_out;
    logic                      ram_we_out;
    logic                      ram_din_out;
    logic                      ram_dout_in;

    visited_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ADDR_W  (ADDR_W),
        .RD_LAT  (RD_LAT)
    ) dut (
        .clk_in           (clk_in),
        .rst_in           (rst_in),
        .clear_in         (clear_in),
        .req_valid_in     (req_valid_in),
        .req_addr_in      (req_addr_in),
        .req_ready_out    (req_ready_out),
        .resp_valid_out   (resp_valid_out),
        .resp_visited_out (resp_visited_out),
        .busy_out         (busy_out),
        .ram_addr_out     (ram_addr_out),
        .ram_we_out       (ram_we_out),
        .ram_din_out      (ram_din_out),
        .ram_dout_in      (ram_dout_in)
    );

    always #5 clk_in = ~clk_in;

    // Read-first BRAM with RD_LAT cycles of read latency.
    logic memBits [DEPTH];
    logic rdPipe  [RD_LAT];

    always @(posedge clk_in) begin
        rdPipe[0] <= memBits[ram_addr_out];
        for (int i = 1; i < RD_LAT; i++) rdPipe[i] <= rdPipe[i-1];
        if (ram_we_out) memBits[ram_addr_out] <= ram_din_out;
    end

    assign ram_dout_in = rdPipe[RD_LAT-1];

    // Reference model state.
    typedef struct {
        int req;
        bit vis;
        int due;
        int addr;
    } exp_t;

    exp_t               expQ[$];
    bit                 visited [DEPTH];
    int                 cyc        = 0;
    int                 freeCyc    = 0;
    int                 clrStart   = NO_CLR;
    int                 mRr        = 0;
    bit                 pendClr    = 1'b0;
    logic [NUM_REQ-1:0] acceptedMask = '0;
    int                 vectors    = 0;
    int                 miscompares = 0;

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    function automatic int pickReq(input logic [NUM_REQ-1:0] v, input int ptr);
        for (int i = 0; i < NUM_REQ; i++) begin
            if (v[(ptr + i) % NUM_REQ]) return (ptr + i) % NUM_REQ;
        end
        return -1;
    endfunction

    // Monitor: predicts accepts, checks sweeps and drains the response queue.
    bit   idleNow;
    bit   inSweep;
    bit   respDue;
    int   g;
    int   gAddr;
    exp_t e;
    logic [NUM_REQ-1:0] expReady;

    always @(negedge clk_in) begin
        cyc++;
        acceptedMask = '0;
        if (!rst_in) begin
            idleNow  = (cyc >= freeCyc);
            expReady = '0;
            checkOutput("busy", busy_out, !idleNow);
            if (idleNow) begin
                if (clear_in || pendClr) begin
                    pendClr  = 1'b0;
                    clrStart = cyc + 1;
                    freeCyc  = cyc + 1 + DEPTH;
                    for (int i = 0; i < DEPTH; i++) visited[i] = 1'b0;
                end else if (req_valid_in != '0) begin
                    g        = pickReq(req_valid_in, mRr);
                    gAddr    = int'(req_addr_in[g*ADDR_W +: ADDR_W]);
                    expReady = NUM_REQ'(1) << g;
                    expQ.push_back('{req: g, vis: visited[gAddr], due: cyc + RD_LAT + 2, addr: gAddr});
                    visited[gAddr] = 1'b1;
                    mRr      = (g + 1) % NUM_REQ;
                    freeCyc  = cyc + RD_LAT + 3;
                end
            end else if (clear_in) begin
                pendClr = 1'b1;
            end
            checkOutput("req_ready", req_ready_out, expReady);
            acceptedMask = req_valid_in & req_ready_out;

            inSweep = (cyc >= clrStart) && (cyc < clrStart + DEPTH);
            if (inSweep) begin
                checkOutput("clear we", ram_we_out, 1);
                checkOutput("clear din", ram_din_out, 0);
                checkOutput("clear addr", ram_addr_out, cyc - clrStart);
            end

            respDue = (expQ.size() > 0) && (expQ[0].due == cyc);
            if (resp_valid_out != '0 || respDue) begin
                if (expQ.size() == 0) begin
                    checkOutput("unexpected resp_valid", resp_valid_out, 0);
                end else begin
                    e = expQ.pop_front();
                    checkOutput("resp cycle", cyc, e.due);
                    checkOutput("resp_valid", resp_valid_out, 1 << e.req);
                    checkOutput("resp_visited", resp_visited_out, e.vis);
                    checkOutput("set we", ram_we_out, !e.vis);
                    if (!e.vis) begin
                        checkOutput("set addr", ram_addr_out, e.addr);
                        checkOutput("set din", ram_din_out, 1);
                    end
                end
            end else if (!inSweep) begin
                checkOutput("idle we", ram_we_out, 0);
            end
        end
    end

    // Stimulus helpers.
    task automatic stepCycle();
        @(posedge clk_in);
        #1;
        req_valid_in = req_valid_in & ~acceptedMask;
        clear_in     = 1'b0;
    endtask

    task automatic applyStimulus(input int idx, input int addr);
        req_valid_in[idx]                  = 1'b1;
        req_addr_in[idx*ADDR_W +: ADDR_W]  = ADDR_W'(addr);
    endtask

    task automatic waitAccepted(input int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            stepCycle();
            done = (req_valid_in == '0);
        end
        checkOutput("accept timeout", done, 1);
    endtask

    task automatic waitIdle(input int budget);
        bit done = 1'b0;
        for (int k = 0; k < budget && !done; k++) begin
            done = (req_valid_in == '0) && (expQ.size() == 0) && (cyc >= freeCyc)
                   && !pendClr && !clear_in;
            if (!done) stepCycle();
        end
        checkOutput("drain timeout", done, 1);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, " req_ready"}, req_ready_out, 0);
        checkOutput({tag, " resp_valid"}, resp_valid_out, 0);
        checkOutput({tag, " resp_visited"}, resp_visited_out, 0);
        checkOutput({tag, " busy"}, busy_out, 0);
        checkOutput({tag, " ram_addr"}, ram_addr_out, 0);
        checkOutput({tag, " ram_we"}, ram_we_out, 0);
        checkOutput({tag, " ram_din"}, ram_din_out, 0);
    endtask

    initial begin
        for (int i = 0; i < DEPTH; i++) memBits[i] = 1'($urandom);
        rst_in       = 1'b1;
        clear_in     = 1'b0;
        req_valid_in = '0;
        req_addr_in  = '0;
        #1;
        checkAllZero("reset");
        repeat (2) stepCycle();
        rst_in = 1'b0;

        // Bitmap starts unknown, so clear it first.
        clear_in = 1'b1;
        waitIdle(3000);

        // Single request, then a repeat that must report visited.
        applyStimulus(0, 5);
        waitIdle(50);
        applyStimulus(0, 5);
        waitIdle(50);

        // Round-robin across all requesters, then requester 0 again.
        for (int i = 0; i < NUM_REQ; i++) applyStimulus(i, 10 + i);
        waitIdle(100);
        applyStimulus(0, 10);
        waitIdle(50);

        // Priority rotation: after requester 2, requester 3 beats 1.
        applyStimulus(2, 20);
        waitAccepted(20);
        applyStimulus(1, 21);
        applyStimulus(3, 22);
        waitIdle(100);

        // Set the extreme addresses, clear, then re-query the middle one.
        applyStimulus(0, 0);
        applyStimulus(1, DEPTH/2 - 1);
        applyStimulus(2, DEPTH - 1);
        waitIdle(100);
        clear_in = 1'b1;
        waitIdle(3000);
        applyStimulus(1, DEPTH/2 - 1);
        waitIdle(50);

        // Clear arriving two cycles into a request, with another waiting.
        applyStimulus(0, 7);
        waitAccepted(20);
        stepCycle();
        clear_in = 1'b1;
        applyStimulus(1, 8);
        waitIdle(3000);

        // Reset two cycles into a request; pointer must return to 0.
        applyStimulus(0, 30);
        waitAccepted(20);
        stepCycle();
        rst_in = 1'b1;
        #1;
        checkAllZero("async reset");
        expQ.delete();
        freeCyc  = 0;
        clrStart = NO_CLR;
        mRr      = 0;
        pendClr  = 1'b0;
        repeat (2) stepCycle();
        rst_in = 1'b0;
        clear_in = 1'b1;
        waitIdle(3000);
        applyStimulus(0, 40);
        applyStimulus(2, 41);
        waitIdle(100);

        // Randomised traffic over a small address range to force hits.
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (!req_valid_in[i] && $urandom_range(0, 2) == 0)
                    applyStimulus(i, int'($urandom_range(0, 31)));
            end
            if ($urandom_range(0, 299) == 0) clear_in = 1'b1;
            stepCycle();
        end
        waitIdle(6000);

        checkOutput("queue empty", expQ.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
